// File: rtl/tc_sched_pkg.sv
// Shared types and constants for the four-way carry-less multiply scheduler.
// Also provides the limb offset arithmetic used for operand selection and accumulation.
package tc_sched_pkg;

    localparam int WIDTH_DEF = 256;
    localparam int SLICE_DEF = WIDTH_DEF / 4;
    localparam int PP_COUNT  = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        ACC   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Bit offset of limb idx within an operand made of slice-wide limbs.
    function automatic int limb_lo(input logic [1:0] idx, input int slice);
        return int'(idx) * slice;
    endfunction

endpackage

// File: rtl/four_way_tc_scheduler_if.sv
// Operand/product handshake bundle between a producer/consumer and the scheduler.
// The master modport belongs to the environment; the slave modport belongs to the scheduler.
interface four_way_tc_scheduler_if #(
    parameter int WIDTH = tc_sched_pkg::WIDTH_DEF
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] c;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c
    );
endinterface

// File: rtl/clmul_serial.sv
// Bit-serial N x N carry-less multiplier: one bit of x per cycle after start.
// done pulses for one cycle while the final bit is being folded in; p then holds until the next start.
module clmul_serial
    import tc_sched_pkg::*;
#(
    parameter int N = SLICE_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic           done,
    output logic [2*N-2:0] p
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] PENULT = CW'(N - 2);
    localparam logic [CW-1:0] LAST   = CW'(N - 1);

    logic [N-1:0]   x_q;
    logic [2*N-2:0] y_sh_q;
    logic [2*N-2:0] p_q;
    logic [2*N-2:0] p_d;
    logic [CW-1:0]  cnt_q;
    logic           run_q;
    logic           done_q;

    // Fold the shifted y into the product when the current x bit is set.
    always_comb begin
        p_d = p_q;
        if (x_q[0]) begin
            p_d = p_q ^ y_sh_q;
        end else begin
            p_d = p_q;
        end
    end

    // Capture on start, then walk x from LSB while y slides left one place per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q    <= '0;
            y_sh_q <= '0;
            p_q    <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (start) begin
            x_q    <= x;
            y_sh_q <= {{(N-1){1'b0}}, y};
            p_q    <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b1;
            done_q <= 1'b0;
        end else if (run_q) begin
            x_q    <= x_q >> 1;
            y_sh_q <= y_sh_q << 1;
            p_q    <= p_d;
            cnt_q  <= cnt_q + 1'b1;
            // Raised one step early so the consumer sees it while the last bit lands.
            done_q <= (cnt_q == PENULT);
            run_q  <= (cnt_q != LAST);
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done = done_q;
    assign p    = p_q;

endmodule

// File: rtl/four_way_tc_scheduler.sv
// Carry-less WIDTH x WIDTH multiply built from 16 limb products issued in order n = 4*i + j
// through a single shared serial multiplier, accumulated at offset SLICE*(i+j).
module four_way_tc_scheduler
    import tc_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    four_way_tc_scheduler_if.slave   bus,
    output logic                     busy,
    output logic [3:0]               pp_idx
);
    localparam int SLICE = WIDTH / 4;
    localparam logic [3:0] LAST_PP = 4'(PP_COUNT - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [3:0]         n_q;
    logic               start_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [SLICE-1:0]   op_x_s;
    logic [SLICE-1:0]   op_y_s;
    logic               mul_done_s;
    logic [2*SLICE-2:0] mul_p_s;

    // Limb operands for the product in flight and the accumulator update it feeds.
    always_comb begin
        op_x_s = a_q[limb_lo(n_q[3:2], SLICE) +: SLICE];
        op_y_s = b_q[limb_lo(n_q[1:0], SLICE) +: SLICE];
        acc_d  = acc_q ^ ({{(2*WIDTH-2*SLICE+1){1'b0}}, mul_p_s}
                          << (limb_lo(n_q[3:2], SLICE) + limb_lo(n_q[1:0], SLICE)));
    end

    clmul_serial #(.N(SLICE)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (start_q),
        .x     (op_x_s),
        .y     (op_y_s),
        .done  (mul_done_s),
        .p     (mul_p_s)
    );

    // Sequencer: accept, issue each limb product, accumulate, present the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            n_q         <= 4'd0;
            start_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        acc_q      <= '0;
                        n_q        <= 4'd0;
                        start_q    <= 1'b1;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    start_q <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (mul_done_s) begin
                        state_q <= ACC;
                    end
                end
                ACC: begin
                    acc_q <= acc_d;
                    if (n_q == LAST_PP) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        n_q     <= n_q + 4'd1;
                        start_q <= 1'b1;
                        state_q <= START;
                    end
                end
                DONE: begin
                    // in_ready rises only after the handshake edge, never alongside it.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    start_q     <= 1'b0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    n_q         <= 4'd0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.c         = acc_q;
    assign busy          = busy_q;
    assign pp_idx        = n_q;

endmodule

// File: tb/tb_four_way_tc_scheduler.sv
// Self-checking bench: random and directed operands checked against a bit-level
// carry-less product model, plus handshake, back-pressure and reset scenarios.
module tb_four_way_tc_scheduler;
    localparam int W         = 256;
    localparam int OV_CYCLE  = 1057;
    localparam int PP_CYCLES = 66;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       busy;
    logic [3:0] pp_idx;
    int         checks = 0;
    int         errors = 0;

    four_way_tc_scheduler_if #(.WIDTH(W)) bus_if ();

    four_way_tc_scheduler #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus_if.slave),
        .busy   (busy),
        .pp_idx (pp_idx)
    );

    always #5 clk = ~clk;

    // Whole-operand shift-and-xor product, independent of any limb split.
    function automatic logic [2*W-1:0] clmul_ref(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (x[i]) r = r ^ ({{W{1'b0}}, y} << i);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        for (int k = 0; k < W / 32; k++) r[32*k +: 32] = $urandom();
        return r;
    endfunction

    // Drives one operation to completion; cyc is the cycle index of first out_valid
    // (acceptance cycle = 0) or -1 on timeout. Optionally keeps in_valid high with junk.
    task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input int hold,
                          input bit keep_iv, input logic [W-1:0] ja, input logic [W-1:0] jb,
                          output logic [2*W-1:0] got, output int cyc,
                          output bit seq_ok, output bit stable_ok, output bit hs_ok);
        int g;
        g = 0; cyc = -1; seq_ok = 1'b1; stable_ok = 1'b1; hs_ok = 1'b1; got = '0;
        bus_if.a = aa; bus_if.b = bb; bus_if.in_valid = 1'b1; bus_if.out_ready = 1'b0;
        while (!bus_if.in_ready && g < 2000) begin @(posedge clk); #1; g++; end
        @(posedge clk); #1;
        if (keep_iv) begin
            bus_if.a = ja; bus_if.b = jb;
        end else begin
            bus_if.in_valid = 1'b0;
        end
        for (int m = 1; m <= OV_CYCLE + 50; m++) begin
            if (bus_if.out_valid) begin cyc = m; break; end
            if (!busy || bus_if.in_ready || pp_idx != 4'((m - 1) / PP_CYCLES)) seq_ok = 1'b0;
            @(posedge clk); #1;
        end
        if (cyc < 0) return;
        got = bus_if.c;
        for (int h = 0; h < hold; h++) begin
            if (!bus_if.out_valid || bus_if.c !== got || bus_if.in_ready) stable_ok = 1'b0;
            @(posedge clk); #1;
        end
        if (!bus_if.out_valid || bus_if.in_ready) stable_ok = 1'b0;
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
        if (!bus_if.in_ready || bus_if.out_valid || busy) hs_ok = 1'b0;
    endtask

    task automatic test_reset();
        bus_if.in_valid = 1'b0; bus_if.out_ready = 1'b0; bus_if.a = '0; bus_if.b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b need 1", bus_if.in_ready); end
        checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b need 0", bus_if.out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b need 0", busy); end
        checks++; if (pp_idx !== 4'd0) begin errors++; $display("FAIL rst_pp_idx got %0d need 0", pp_idx); end
        checks++; if (bus_if.c !== '0) begin errors++; $display("FAIL rst_c got %h need 0", bus_if.c); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus_if.in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_rst_idle got in_ready=%b busy=%b need 1/0", bus_if.in_ready, busy); end
    endtask

    task automatic test_directed();
        logic [W-1:0]   x [4];
        logic [W-1:0]   y [4];
        logic [2*W-1:0] e [4];
        logic [2*W-1:0] got;
        int cyc; bit sq, st, hs;
        x[0] = W'(1); y[0] = W'(1); e[0] = (2*W)'(1);
        x[1] = W'(3); y[1] = W'(3); e[1] = (2*W)'(5);
        x[2] = '0; x[2][W-1] = 1'b1; y[2] = x[2]; e[2] = '0; e[2][2*W-2] = 1'b1;
        x[3] = '1; y[3] = '1; e[3] = {W{2'b01}};
        for (int t = 0; t < 4; t++) begin
            run_op(x[t], y[t], 0, 1'b0, '0, '0, got, cyc, sq, st, hs);
            checks++; if (cyc != OV_CYCLE) begin errors++; $display("FAIL dir%0d_latency got %0d need %0d", t, cyc, OV_CYCLE); end
            checks++; if (got !== e[t]) begin errors++; $display("FAIL dir%0d_c got %h need %h", t, got, e[t]); end
            checks++; if (!sq) begin errors++; $display("FAIL dir%0d_busy_ppidx got bad need busy=1 pp_idx=(cycle-1)/66", t); end
            checks++; if (!hs) begin errors++; $display("FAIL dir%0d_handshake got bad need in_ready=1 out_valid=0 busy=0", t); end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] x, y; logic [2*W-1:0] got; int cyc; bit sq, st, hs;
        x = rand_w(); y = rand_w();
        run_op(x, y, 20, 1'b0, '0, '0, got, cyc, sq, st, hs);
        checks++; if (got !== clmul_ref(x, y)) begin errors++; $display("FAIL bp_c got %h need %h", got, clmul_ref(x, y)); end
        checks++; if (!st) begin errors++; $display("FAIL bp_stable got unstable need c/out_valid held, in_ready=0"); end
        checks++; if (!hs) begin errors++; $display("FAIL bp_handshake got bad need in_ready=1 after handshake"); end
    endtask

    task automatic test_busy_ignore();
        logic [W-1:0] x, y, jx, jy; logic [2*W-1:0] got; int cyc; bit sq, st, hs;
        x = rand_w(); y = rand_w(); jx = rand_w(); jy = rand_w();
        run_op(x, y, 3, 1'b1, jx, jy, got, cyc, sq, st, hs);
        checks++; if (got !== clmul_ref(x, y)) begin errors++; $display("FAIL ign_c got %h need %h", got, clmul_ref(x, y)); end
        checks++; if (!hs || !st) begin errors++; $display("FAIL ign_handshake got bad need no capture until IDLE"); end
        // in_valid is still high: the pending operands are taken only now, from IDLE.
        run_op(jx, jy, 0, 1'b0, '0, '0, got, cyc, sq, st, hs);
        checks++; if (got !== clmul_ref(jx, jy) || cyc != OV_CYCLE) begin errors++; $display("FAIL ign_next got %h cyc %0d need %h cyc %0d", got, cyc, clmul_ref(jx, jy), OV_CYCLE); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] x, y; logic [2*W-1:0] got; int cyc, g, seen, bad; bit sq, st, hs;
        x = rand_w(); y = rand_w(); g = 0;
        bus_if.a = x; bus_if.b = y; bus_if.in_valid = 1'b1;
        while (!bus_if.in_ready && g < 2000) begin @(posedge clk); #1; g++; end
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        repeat (499) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checks++; if (bus_if.in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_idle got in_ready=%b busy=%b need 1/0", bus_if.in_ready, busy); end
        checks++; if (bus_if.out_valid !== 1'b0 || pp_idx !== 4'd0) begin errors++; $display("FAIL mid_rst_clear got out_valid=%b pp_idx=%0d need 0/0", bus_if.out_valid, pp_idx); end
        @(negedge clk); rst = 1'b1;
        seen = 0; bad = 0;
        for (int m = 0; m < 1200; m++) begin
            @(posedge clk); #1;
            if (bus_if.out_valid) seen++;
            if (!bus_if.in_ready || busy) bad++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL mid_rst_no_out got %0d out_valid cycles need 0", seen); end
        checks++; if (bad != 0) begin errors++; $display("FAIL mid_rst_stays_idle got %0d busy cycles need 0", bad); end
        x = rand_w(); y = rand_w();
        run_op(x, y, 0, 1'b0, '0, '0, got, cyc, sq, st, hs);
        checks++; if (got !== clmul_ref(x, y) || cyc != OV_CYCLE) begin errors++; $display("FAIL mid_rst_next got %h cyc %0d need %h cyc %0d", got, cyc, clmul_ref(x, y), OV_CYCLE); end
    endtask

    task automatic test_random();
        logic [W-1:0] x, y; logic [2*W-1:0] got; int cyc; bit sq, st, hs;
        for (int t = 0; t < 4; t++) begin
            x = rand_w(); y = rand_w();
            if (t == 1) x[W-1 -: 32] = 32'hFFFF_FFFF;
            run_op(x, y, int'($urandom_range(0, 5)), 1'b0, '0, '0, got, cyc, sq, st, hs);
            checks++; if (got !== clmul_ref(x, y)) begin errors++; $display("FAIL rnd%0d_c got %h need %h", t, got, clmul_ref(x, y)); end
            checks++; if (cyc != OV_CYCLE || !sq || !st || !hs) begin errors++; $display("FAIL rnd%0d_timing got cyc %0d seq %b stab %b hs %b need %0d 1 1 1", t, cyc, sq, st, hs, OV_CYCLE); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
